// File: rtl/mul_arbiter_pkg.sv
// Shared types and default sizing for the multiplier arbiter.
// Holds the FSM state encoding and the round-robin pointer step.
package mul_arb_pkg;

    localparam int LEN_DEF     = 32;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Index following g in a ring of n requesters.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mul_arbiter_if #(
    parameter int LEN  = mul_arb_pkg::LEN_DEF,
    parameter int NREQ = mul_arb_pkg::NREQ_DEF
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*LEN-1:0] req_a;
    logic [NREQ*LEN-1:0] req_b;

    logic                mul_start;
    logic [LEN-1:0]      mul_multiplicand;
    logic [LEN-1:0]      mul_multiplier;
    logic [2*LEN-1:0]    mul_product;
    logic                mul_finish;

    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [2*LEN-1:0]    rsp_product;
    logic                rsp_err;
    logic                rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, mul_product, mul_finish, rsp_ready,
        output req_ready, mul_start, mul_multiplicand, mul_multiplier,
               rsp_valid, rsp_id, rsp_product, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, mul_product, mul_finish, rsp_ready,
        input  req_ready, mul_start, mul_multiplicand, mul_multiplier,
               rsp_valid, rsp_id, rsp_product, rsp_err
    );

endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int             j;
    logic [IDW-1:0] jj;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDW'(j);
            if (req[jj]) begin
                grant     = '0;
                grant[jj] = 1'b1;
                idx       = jj;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external multiplier among NREQ requesters with round-robin
// grant, a start pulse per operation, a finish timeout and a held response.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int LEN     = LEN_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic          clk,
    input logic          rst,
    mul_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_n;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  own_id;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            any;

    logic            take;
    logic            done;
    logic            timed_out;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    take    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = BUSY;
            BUSY: begin
                // A finish on the last allowed cycle still counts as success.
                if (bus.mul_finish) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
    assign bus.mul_start = (state == ISSUE);
    assign bus.rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                  <= '0;
            own_id               <= '0;
            cnt                  <= '0;
            bus.mul_multiplicand <= '0;
            bus.mul_multiplier   <= '0;
            bus.rsp_id           <= '0;
            bus.rsp_product      <= '0;
            bus.rsp_err          <= 1'b0;
        end else begin
            if (take) begin
                bus.mul_multiplicand <= bus.req_a[gidx*LEN +: LEN];
                bus.mul_multiplier   <= bus.req_b[gidx*LEN +: LEN];
                own_id               <= gidx;
                ptr                  <= IDW'(rr_next(int'(gidx), NREQ));
                cnt                  <= '0;
            end
            if (state == BUSY && !done && !timed_out) cnt <= cnt + CW'(1);
            // Response fields only change on entry to RESP so they stay put while held.
            if (done) begin
                bus.rsp_id      <= own_id;
                bus.rsp_product <= bus.mul_product;
                bus.rsp_err     <= 1'b0;
            end else if (timed_out) begin
                bus.rsp_id      <= own_id;
                bus.rsp_product <= '0;
                bus.rsp_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural multiplier, reference round-robin model
// and a response scoreboard fed at grant time.
module tb_mul_arbiter;

    localparam int LEN  = 32;
    localparam int NREQ = 4;
    localparam int TMO  = 8;
    localparam int LAT  = 3;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rv;
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic        rr;
    logic        mul_en;
    logic        stray;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_arbiter_if #(.LEN(LEN), .NREQ(NREQ)) bus();

    mul_arbiter #(.LEN(LEN), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_valid = rv;
    assign bus.req_a     = {ra[3], ra[2], ra[1], ra[0]};
    assign bus.req_b     = {rb[3], rb[2], rb[1], rb[0]};
    assign bus.rsp_ready = rr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural multiplier with fixed latency; mul_en=0 makes it never finish.
    logic        mf_q;
    logic [63:0] mp_q;
    logic [63:0] m_res;
    int          m_cnt;
    logic        m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            mf_q   <= 1'b0;
            mp_q   <= '0;
            m_res  <= '0;
            m_cnt  <= 0;
        end else begin
            mf_q <= 1'b0;
            if (bus.mul_start) begin
                m_busy <= mul_en;
                m_cnt  <= LAT;
                m_res  <= {32'd0, bus.mul_multiplicand} * {32'd0, bus.mul_multiplier};
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    mf_q   <= 1'b1;
                    mp_q   <= m_res;
                    m_busy <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign bus.mul_finish  = mf_q | stray;
    assign bus.mul_product = mp_q;

    function automatic int model_pick(input logic [3:0] v, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    exp_t        sb [$];
    int          gseq [$];
    int          mptr = 0;
    int          cyc = 0;
    int          starts = 0;
    int          start_cyc = 0;
    int          rise_cyc = 0;
    logic        prev_rv = 1'b0;
    logic [1:0]  last_id = '0;
    logic [63:0] last_prod = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   eg;
        cyc++;
        if (rst) begin
            sb.delete();
            mptr    = 0;
            starts  = 0;
            prev_rv = 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                eg = model_pick(rv, mptr);
                check_eq("rdy_onehot", $countones(bus.req_ready), 1);
                check_eq("grant", bus.req_ready, (eg < 0) ? 64'd0 : (64'd1 << eg));
                check_eq("rdy_while_busy", sb.size(), 0);
                if (eg >= 0) begin
                    e.id   = 2'(eg);
                    e.a    = ra[eg];
                    e.b    = rb[eg];
                    e.err  = !mul_en;
                    e.prod = mul_en ? ({32'd0, ra[eg]} * {32'd0, rb[eg]}) : 64'd0;
                    sb.push_back(e);
                    gseq.push_back(eg);
                    mptr = (eg + 1) % 4;
                end
            end
            if (bus.mul_start) begin
                starts++;
                start_cyc = cyc;
                if (sb.size() != 0) begin
                    check_eq("op_a", bus.mul_multiplicand, sb[0].a);
                    check_eq("op_b", bus.mul_multiplier, sb[0].b);
                end
            end
            if (bus.rsp_valid && !prev_rv) rise_cyc = cyc;
            prev_rv = bus.rsp_valid;
            if (bus.rsp_valid && rr) begin
                check_eq("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_id", bus.rsp_id, e.id);
                    check_eq("rsp_product", bus.rsp_product, e.prod);
                    check_eq("rsp_err", bus.rsp_err, e.err);
                    check_eq("start_pulses", starts, 1);
                    starts    = 0;
                    last_id   = bus.rsp_id;
                    last_prod = bus.rsp_product;
                    last_err  = bus.rsp_err;
                end
            end
        end
    end

    task automatic start_req(input int id, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        rv[id] = 1'b1;
        ra[id] = a;
        rb[id] = b;
    endtask

    task automatic wait_grant(input int id);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1'b1;
        end
        check_eq($sformatf("grant_seen_%0d", id), got, 1);
        if (got) begin
            @(posedge clk); #1;
            rv[id] = 1'b0;
        end
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b);
        start_req(id, a, b);
        wait_grant(id);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (sb.size() != 0 || bus.rsp_valid); n++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_req_ready"}, bus.req_ready, 0);
        check_eq({pfx, "_mul_start"}, bus.mul_start, 0);
        check_eq({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({pfx, "_rsp_id"}, bus.rsp_id, 0);
        check_eq({pfx, "_rsp_product"}, bus.rsp_product, 0);
        check_eq({pfx, "_rsp_err"}, bus.rsp_err, 0);
        check_eq({pfx, "_mcand"}, bus.mul_multiplicand, 0);
        check_eq({pfx, "_mplier"}, bus.mul_multiplier, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  hid;
        logic [63:0] hp;
        logic        seen;
        rr     = 1'b1;
        mul_en = 1'b1;
        stray  = 1'b0;
        rst    = 1'b1;
        rv     = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 32'(i + 1);
            rb[i] = 32'(10 * (i + 1));
        end

        // Reset: all requesters already valid, nothing may be accepted.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous requests from reset: order 0,1,2,3,0.
        for (int n = 0; n < 200 && gseq.size() < 5; n++) begin
            @(posedge clk); #1;
        end
        rv = 4'h0;
        check_eq("rr_count", gseq.size(), 5);
        if (gseq.size() >= 5)
            for (int k = 0; k < 5; k++) check_eq($sformatf("rr_order%0d", k), gseq[k], k % 4);
        drain();

        // Single request.
        send(2, 32'd3, 32'd5);
        drain();
        check_eq("single_id", last_id, 2);
        check_eq("single_prod", last_prod, 64'd15);

        // Full-scale operands.
        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check_eq("max_prod", last_prod, 64'hFFFF_FFFE_0000_0001);

        // Response held off for 10 cycles with another requester waiting.
        rr = 1'b0;
        send(0, 32'd7, 32'd9);
        for (int n = 0; n < 50 && !bus.rsp_valid; n++) @(negedge clk);
        check_eq("hold_rsp_seen", bus.rsp_valid, 1);
        hid = bus.rsp_id;
        hp  = bus.rsp_product;
        start_req(3, 32'd11, 32'd13);
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_valid", bus.rsp_valid, 1);
            check_eq("hold_id", bus.rsp_id, hid);
            check_eq("hold_prod", bus.rsp_product, hp);
            check_eq("hold_no_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        rr = 1'b1;
        wait_grant(3);
        drain();

        // Multiplier never finishes: timeout after TMO busy cycles.
        mul_en = 1'b0;
        send(0, 32'd5, 32'd6);
        drain();
        check_eq("tmo_latency", rise_cyc - start_cyc, TMO + 1);
        check_eq("tmo_err", last_err, 1);
        check_eq("tmo_prod", last_prod, 0);
        mul_en = 1'b1;

        // Finish pulse while idle must not produce a response.
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        seen  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check_eq("stray_ignored", seen, 0);

        // Reset during BUSY drops the operation and rewinds the pointer.
        mul_en = 1'b0;
        send(2, 32'd2, 32'd2);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.mul_start;
        end
        check_eq("busy_start_seen", seen, 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("busy_reset");
        rst    = 1'b0;
        mul_en = 1'b1;
        gseq.delete();
        @(posedge clk); #1;
        rv[1] = 1'b1; ra[1] = 32'd4; rb[1] = 32'd5;
        rv[3] = 1'b1; ra[3] = 32'd6; rb[3] = 32'd7;
        wait_grant(1);
        wait_grant(3);
        drain();
        check_eq("post_rst_count", gseq.size(), 2);
        if (gseq.size() >= 2) begin
            check_eq("post_rst_first", gseq[0], 1);
            check_eq("post_rst_second", gseq[1], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter LEN, default 32, operand width; product width is 2*LEN.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter TIMEOUT, default 255, maximum number of cycles to wait for mul_finish.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_a / req_b  input  NREQ*LEN each  packed per-requester multiplicand / multiplier.
REQ-008 req_ready  output  NREQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mul_start  output  1  one-cycle start pulse to the Multiplier.
REQ-010 mul_multiplicand / mul_multiplier  output  LEN each  operands to the Multiplier.
REQ-011 mul_product  input  2*LEN  Multiplier result.
REQ-012 mul_finish  input  1  Multiplier done pulse.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_id  output  $clog2(NREQ)  index of the requester that owns the response.
REQ-015 rsp_product  output  2*LEN  result of the multiply.
REQ-016 rsp_err  output  1  high if the response was produced by timeout.
REQ-017 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP.
REQ-019 IDLE: if any req_valid is high, the arbiter SHALL assert req_ready for exactly one requester that cycle, latch its operands and id, and go to ISSUE.
REQ-020 Grant SHALL be round-robin: search starts at pointer ptr and wraps modulo NREQ; on grant of index g, ptr becomes (g+1) mod NREQ.
REQ-021 req_ready SHALL be all-zero in every state except IDLE.
REQ-022 ISSUE: mul_start SHALL be 1 for exactly one cycle, then the FSM goes to BUSY; mul_start SHALL be 0 in all other states.
REQ-023 mul_multiplicand and mul_multiplier SHALL hold the latched operands, stable from ISSUE until the FSM leaves BUSY.
REQ-024 BUSY: on mul_finish, mul_product SHALL be captured into rsp_product, with rsp_err=0, and the FSM goes to RESP.
REQ-025 BUSY SHALL count cycles; if TIMEOUT cycles elapse without mul_finish, the FSM goes to RESP with rsp_product=0 and rsp_err=1.
REQ-026 mul_finish outside BUSY SHALL be ignored.
REQ-027 RESP: rsp_valid=1 with rsp_id, rsp_product and rsp_err stable until rsp_ready; on handshake, the FSM goes to IDLE.
REQ-028 Minimum occupancy per operation SHALL be 1 (IDLE grant) + 1 (ISSUE) + multiplier latency + 1 (RESP) cycles; no new grant occurs in the same cycle as a response handshake.

Reset
REQ-029 With rst high at a clock edge:
  - state=IDLE, ptr=0, timeout counter=0
  - all outputs 0: req_ready, mul_start, mul_multiplicand, mul_multiplier, rsp_valid, rsp_id, rsp_product, rsp_err
  - any in-flight operation is dropped with no response.
REQ-030 req_ready SHALL be 0 while rst is high.

Structure
REQ-031 Package mul_arb_pkg SHALL hold the state enum type and the default LEN, NREQ and TIMEOUT constants.
REQ-032 The round-robin selector SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: one-hot grant, index, any).
REQ-033 The Multiplier SHALL be instantiated outside mul_arbiter, sharing clk and rst.

Verification
REQ-034 Single request: requester 2 with a=3, b=5 -> one ISSUE pulse, rsp_id=2, rsp_product=15, rsp_err=0.
REQ-035 All four requesters valid continuously from reset -> grant order 0,1,2,3,0, with exactly one req_ready high per grant.
REQ-036 Requester 1 with a=32'hFFFFFFFF, b=32'hFFFFFFFF -> rsp_product=64'hFFFFFFFE00000001.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid, rsp_id and rsp_product unchanged, and no req_ready asserted until the handshake.
REQ-038 mul_finish tied low, TIMEOUT=8 -> RESP after 8 BUSY cycles with rsp_err=1 and rsp_product=0.
REQ-039 rst asserted during BUSY -> next cycle all outputs are 0 and ptr=0; the next grant goes to the lowest valid index.
